// File: rtl/hub75_frame_scanner.sv
// HUB75 panel scanner: reads paired upper/lower framebuffer words and drives the
// panel with binary code modulation, one bit plane per SHIFT/LATCH/DISPLAY pass.
module hub75_frame_scanner #(
    parameter int NUM_BLOCK_ROWS = 16,
    parameter int NUM_PIXELS     = 128,
    parameter int LOG_POWER_MOD  = 4,
    parameter int BASE_ON_CYCLES = 8,
    localparam int LOG_ROWS      = $clog2(NUM_BLOCK_ROWS),
    localparam int ADDRESS_SIZE  = $clog2(NUM_BLOCK_ROWS * NUM_PIXELS),
    localparam int PIXEL_SIZE    = 3 * LOG_POWER_MOD
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    enable_in,
    output logic [ADDRESS_SIZE-1:0] read_address,
    input  logic [PIXEL_SIZE-1:0]   upper_read_data,
    input  logic [PIXEL_SIZE-1:0]   lower_read_data,
    output logic                    hub_r1,
    output logic                    hub_g1,
    output logic                    hub_b1,
    output logic                    hub_r2,
    output logic                    hub_g2,
    output logic                    hub_b2,
    output logic                    hub_clk,
    output logic                    hub_lat,
    output logic                    hub_oe_n,
    output logic [LOG_ROWS-1:0]     hub_addr,
    output logic                    frame_done
);

    localparam int COL_W   = $clog2(NUM_PIXELS) + 1;
    localparam int PLANE_W = (LOG_POWER_MOD > 1) ? $clog2(LOG_POWER_MOD) : 1;
    localparam int DISP_W  = $clog2((BASE_ON_CYCLES << (LOG_POWER_MOD - 1)) + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SHIFT   = 2'd1;
    localparam logic [1:0] S_LATCH   = 2'd2;
    localparam logic [1:0] S_DISPLAY = 2'd3;

    logic [1:0]              state_q, state_d;
    logic [COL_W-1:0]        col_q, col_d;
    logic                    phase_q, phase_d;
    logic [DISP_W-1:0]       disp_q, disp_d;
    logic [LOG_ROWS-1:0]     row_q, row_d;
    logic [PLANE_W-1:0]      plane_q, plane_d;
    logic                    done_d;
    logic [DISP_W-1:0]       on_len_s;
    logic                    fetch_s;
    logic                    capture_s;
    logic [ADDRESS_SIZE-1:0] addr_d;

    logic [ADDRESS_SIZE-1:0] read_address_q;
    logic [2:0]              upper_rgb_q, lower_rgb_q;
    logic                    hub_clk_q, hub_lat_q, hub_oe_n_q, frame_done_q;
    logic [LOG_ROWS-1:0]     hub_addr_q;

    function automatic logic [2:0] plane_bits(input logic [PIXEL_SIZE-1:0] word,
                                              input logic [PLANE_W-1:0]    plane);
        logic [LOG_POWER_MOD-1:0] r_f, g_f, b_f;
        r_f = word[3*LOG_POWER_MOD-1:2*LOG_POWER_MOD];
        g_f = word[2*LOG_POWER_MOD-1:LOG_POWER_MOD];
        b_f = word[LOG_POWER_MOD-1:0];
        return {r_f[plane], g_f[plane], b_f[plane]};
    endfunction

    assign on_len_s = DISP_W'(BASE_ON_CYCLES) << plane_q;

    // Scan sequencer: one SHIFT cycle is indexed as 2*col + phase.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        phase_d = phase_q;
        disp_d  = disp_q;
        row_d   = row_q;
        plane_d = plane_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable_in) begin
                    state_d = S_SHIFT;
                    col_d   = COL_W'(0);
                    phase_d = 1'b0;
                    row_d   = LOG_ROWS'(0);
                    plane_d = PLANE_W'(0);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                if ((col_q == COL_W'(NUM_PIXELS)) && phase_q) begin
                    state_d = S_LATCH;
                end else begin
                    phase_d = ~phase_q;
                    col_d   = phase_q ? (col_q + COL_W'(1)) : col_q;
                end
            end
            S_LATCH: begin
                state_d = S_DISPLAY;
                disp_d  = DISP_W'(0);
            end
            S_DISPLAY: begin
                if (disp_q == (on_len_s - DISP_W'(1))) begin
                    col_d   = COL_W'(0);
                    phase_d = 1'b0;
                    if (plane_q != PLANE_W'(LOG_POWER_MOD - 1)) begin
                        plane_d = plane_q + PLANE_W'(1);
                        state_d = S_SHIFT;
                    end else if (row_q != LOG_ROWS'(NUM_BLOCK_ROWS - 1)) begin
                        row_d   = row_q + LOG_ROWS'(1);
                        plane_d = PLANE_W'(0);
                        state_d = S_SHIFT;
                    end else begin
                        row_d   = LOG_ROWS'(0);
                        plane_d = PLANE_W'(0);
                        done_d  = 1'b1;
                        state_d = enable_in ? S_SHIFT : S_IDLE;
                    end
                end else begin
                    disp_d = disp_q + DISP_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Address for the next cycle, and whether the word arriving now belongs to a column.
    always_comb begin
        fetch_s   = (state_d == S_SHIFT) && !phase_d && (col_d < COL_W'(NUM_PIXELS));
        capture_s = (state_q == S_SHIFT) && phase_q && (col_q < COL_W'(NUM_PIXELS));
        if (fetch_s) begin
            addr_d = ADDRESS_SIZE'(row_d) * ADDRESS_SIZE'(NUM_PIXELS) + ADDRESS_SIZE'(col_d);
        end else begin
            addr_d = read_address_q;
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= S_IDLE;
            col_q   <= COL_W'(0);
            phase_q <= 1'b0;
            disp_q  <= DISP_W'(0);
            row_q   <= LOG_ROWS'(0);
            plane_q <= PLANE_W'(0);
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            phase_q <= phase_d;
            disp_q  <= disp_d;
            row_q   <= row_d;
            plane_q <= plane_d;
        end
    end

    // Panel pins are derived from next-state so every pin is a flop output.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            read_address_q <= ADDRESS_SIZE'(0);
            upper_rgb_q    <= 3'b000;
            lower_rgb_q    <= 3'b000;
            hub_clk_q      <= 1'b0;
            hub_lat_q      <= 1'b0;
            hub_oe_n_q     <= 1'b1;
            hub_addr_q     <= LOG_ROWS'(0);
            frame_done_q   <= 1'b0;
        end else begin
            read_address_q <= addr_d;
            if (capture_s) begin
                upper_rgb_q <= plane_bits(upper_read_data, plane_q);
                lower_rgb_q <= plane_bits(lower_read_data, plane_q);
            end
            hub_clk_q  <= (state_d == S_SHIFT) && phase_d && (col_d != COL_W'(0));
            hub_lat_q  <= (state_d == S_LATCH);
            hub_oe_n_q <= (state_d != S_DISPLAY);
            if (state_d == S_LATCH) begin
                hub_addr_q <= row_d;
            end
            frame_done_q <= done_d;
        end
    end

    assign read_address = read_address_q;
    assign {hub_r1, hub_g1, hub_b1} = upper_rgb_q;
    assign {hub_r2, hub_g2, hub_b2} = lower_rgb_q;
    assign hub_clk    = hub_clk_q;
    assign hub_lat    = hub_lat_q;
    assign hub_oe_n   = hub_oe_n_q;
    assign hub_addr   = hub_addr_q;
    assign frame_done = frame_done_q;

endmodule
